// File: rtl/prime_scan_ctrl.sv
// Range sequencer for a combinational prime detector: steps num from lo to hi,
// one candidate per clock, and streams the primes it finds with a running count.
module prime_scan_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] num,
  input  logic             resultado,
  output logic             prime_valid,
  output logic [WIDTH-1:0] prime_out,
  output logic [WIDTH:0]   count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] NUM_ONE = 1;
  localparam logic [WIDTH:0]   CNT_ONE = 1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] hi_q;
  logic             range_err;
  logic             last_cand;

  assign range_err = (lo > hi);
  // The end test looks at the current candidate, so hi = all-ones never wraps num.
  assign last_cand = (num == hi_q);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = range_err ? FIN : SCAN;
      SCAN:    if (abort || last_cand) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Candidate/result stage: resultado for the candidate held in num is
  // registered here, so each strobe trails its candidate by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num         <= '0;
      hi_q        <= '0;
      prime_out   <= '0;
      count       <= '0;
      prime_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      busy        <= (state_nx == SCAN);
      done        <= (state_nx == FIN);
      err         <= (state == IDLE) && start && range_err;
      prime_valid <= (state == SCAN) && resultado;
      case (state)
        IDLE: begin
          if (start) begin
            hi_q  <= hi;
            count <= '0;
            if (!range_err) num <= lo;
          end
        end
        SCAN: begin
          if (resultado) begin
            prime_out <= num;
            count     <= count + CNT_ONE;
          end
          if (!last_cand && !abort) num <= num + NUM_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Scoreboard bench for prime_scan_ctrl: a trial-division detector drives
// resultado, and a range-level model predicts every strobe and done pulse.
module tb_prime_scan_ctrl;
  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] lo = '0;
  logic [WIDTH-1:0] hi = '0;
  logic [WIDTH-1:0] num;
  logic             resultado;
  logic             prime_valid;
  logic [WIDTH-1:0] prime_out;
  logic [WIDTH:0]   count;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_run = 0;
  int model_num = 0;
  int model_cnt = 0;

  typedef struct {
    bit is_done;
    int val;
    int cyc;
    int cnt;
    bit err;
    int busy_n;
    int num_hold;
  } exp_t;

  exp_t expq[$];

  prime_scan_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .num(num), .resultado(resultado), .prime_valid(prime_valid),
    .prime_out(prime_out), .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d < v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  assign resultado = is_prime(int'(num));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response of one scan accepted at edge t0; ab = abort offset or -1.
  task automatic model_scan(input int l, input int h, input int ab);
    exp_t e;
    int last;
    int cnt;
    if (l > h) begin
      e = '{1'b1, 0, t0, 0, 1'b1, 0, model_num};
      expq.push_back(e);
      model_cnt = 0;
    end else begin
      last = (ab >= 0 && l + ab < h) ? l + ab : h;
      cnt = 0;
      for (int c = l; c <= last; c++) begin
        if (is_prime(c)) begin
          e = '{1'b0, c, t0 + (c - l) + 1, 0, 1'b0, 0, 0};
          expq.push_back(e);
          cnt++;
        end
      end
      e = '{1'b1, 0, t0 + (last - l) + 1, cnt, 1'b0, last - l + 1, last};
      expq.push_back(e);
      model_num = last;
      model_cnt = cnt;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy) busy_run++;
      if (prime_valid) begin
        if (expq.size() == 0 || expq[0].is_done) begin
          checks++; errors++;
          $display("FAIL spurious_prime: got strobe with prime_out=%0d expected none (cycle %0d)", prime_out, cyc);
        end else begin
          e = expq.pop_front();
          check("prime_out", int'(prime_out), e.val);
          check("prime_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (expq.size() == 0 || !expq[0].is_done) begin
          checks++; errors++;
          $display("FAIL spurious_done: got done expected none (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_err", int'(err), int'(e.err));
          check("done_count", int'(count), e.cnt);
          check("busy_cycles", busy_run, e.busy_n);
          check("num_hold", int'(num), e.num_hold);
        end
        busy_run = 0;
      end else if (err) begin
        checks++; errors++;
        $display("FAIL err_without_done: got err=1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic wait_drain();
    #1;
    for (int i = 0; i < 40; i++) begin
      if (expq.size() == 0) break;
      @(negedge clk); #1;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending events expected 0", expq.size());
      expq.delete();
    end
  endtask

  // ab: abort offset into the scan (-1 none); rs: offset of an extra start pulse (-1 none).
  task automatic run_scan(input int l, input int h, input int ab, input int rs);
    int n;
    @(negedge clk);
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    lo = WIDTH'(l);
    hi = WIDTH'(h);
    t0 = cyc + 1;
    model_scan(l, h, ab);
    n = (l > h) ? 1 : h - l + 1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = (k == rs);
      abort = (k == ab);
      if (k == rs) begin
        lo = WIDTH'($urandom);
        hi = WIDTH'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    wait_drain();
    @(negedge clk); #1;
    check("count_held", int'(count), model_cnt);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
  endtask

  initial begin
    int l, h, ab, rs;
    repeat (2) @(negedge clk);
    #1;
    check("rst_num", int'(num), 0);
    check("rst_prime_out", int'(prime_out), 0);
    check("rst_count", int'(count), 0);
    check("rst_prime_valid", int'(prime_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_scan(0, 15, -1, -1);
    run_scan(8, 12, -1, -1);
    run_scan(13, 13, -1, -1);
    run_scan(9, 9, -1, -1);
    run_scan(10, 3, -1, -1);
    run_scan(0, 15, 5, 2);
    run_scan(3, 3, 0, 0);

    // Reset in the middle of a full sweep, then the sweep again from scratch.
    @(negedge clk);
    start = 1'b1; lo = '0; hi = WIDTH'(MAXV);
    t0 = cyc + 1;
    model_scan(0, MAXV, -1);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_num", int'(num), 7);
    #2 rst_n = 1'b0;
    #1;
    expq.delete();
    busy_run = 0;
    model_num = 0;
    model_cnt = 0;
    check("arst_num", int'(num), 0);
    check("arst_prime_out", int'(prime_out), 0);
    check("arst_count", int'(count), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_prime_valid", int'(prime_valid), 0);
    repeat (2) @(negedge clk);
    check("arst_done", int'(done), 0);
    rst_n = 1'b1;
    run_scan(0, 15, -1, -1);

    for (int i = 0; i < 30; i++) begin
      l = $urandom_range(0, MAXV);
      h = ($urandom_range(0, 5) == 0) ? $urandom_range(0, MAXV) : $urandom_range(l, MAXV);
      ab = -1;
      rs = -1;
      if (l <= h) begin
        if ($urandom_range(0, 2) == 0) ab = $urandom_range(0, h - l);
        if ($urandom_range(0, 1) == 0) rs = $urandom_range(0, (ab >= 0) ? ab : h - l);
      end
      run_scan(l, h, ab, rs);
    end

    check("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
